// File: rtl/alu_cmd_sequencer.sv
// Request sequencer for a combinational N-bit ALU: buffers requests, issues them one at a
// time, returns the captured result and checks it against an internal reference.
module alu_cmd_sequencer #(
   parameter int N     = 4,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [N-1:0] req_op1,
   input  logic [N-1:0] req_op2,
   input  logic [1:0]   req_opcode,
   output logic [N-1:0] alu_operand1,
   output logic [N-1:0] alu_operand2,
   output logic [1:0]   alu_operation,
   input  logic [N:0]   alu_result,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N:0]   rsp_result,
   output logic [1:0]   rsp_opcode,
   output logic         rsp_mismatch,
   output logic [7:0]   err_count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESPOND} state_t;

   logic [N-1:0]  r_fifo_op1 [DEPTH];
   logic [N-1:0]  r_fifo_op2 [DEPTH];
   logic [1:0]    r_fifo_opc [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   state_t        r_state;
   logic [N-1:0]  r_op1;
   logic [N-1:0]  r_op2;
   logic [1:0]    r_opc;
   logic          r_rsp_valid;
   logic [N:0]    r_rsp_result;
   logic [1:0]    r_rsp_opcode;
   logic          r_rsp_mismatch;
   logic [7:0]    r_err_count;

   logic          w_push;
   logic          w_pop;
   logic [N:0]    w_a;
   logic [N:0]    w_b;
   logic [N:0]    w_model;
   logic          w_mismatch;

   assign req_ready = (r_count < DEPTH_C);
   assign w_push    = req_valid && req_ready;
   assign w_pop     = (r_state == S_IDLE) && (r_count != '0);

   // Storage has no reset so it can map onto distributed/block RAM.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_op1[r_wr_ptr] <= req_op1;
         r_fifo_op2[r_wr_ptr] <= req_op2;
         r_fifo_opc[r_wr_ptr] <= req_opcode;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_a = {1'b0, r_op1};
   assign w_b = {1'b0, r_op2};

   always_comb begin
      w_model = '0;
      unique case (r_opc)
         2'b00:   w_model = w_a + w_b;
         2'b01:   w_model = w_a - w_b;
         2'b10:   w_model = w_a & w_b;
         default: w_model = w_a | w_b;
      endcase
   end

   assign w_mismatch = (alu_result != w_model);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_op1          <= '0;
         r_op2          <= '0;
         r_opc          <= '0;
         r_rsp_valid    <= 1'b0;
         r_rsp_result   <= '0;
         r_rsp_opcode   <= '0;
         r_rsp_mismatch <= 1'b0;
         r_err_count    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_op1   <= r_fifo_op1[r_rd_ptr];
                  r_op2   <= r_fifo_op2[r_rd_ptr];
                  r_opc   <= r_fifo_opc[r_rd_ptr];
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: r_state <= S_CAPTURE;
            S_CAPTURE: begin
               r_rsp_result   <= alu_result;
               r_rsp_opcode   <= r_opc;
               r_rsp_mismatch <= w_mismatch;
               r_rsp_valid    <= 1'b1;
               if (w_mismatch && (r_err_count != 8'hFF))
                  r_err_count <= r_err_count + 1'b1;
               r_state <= S_RESPOND;
            end
            S_RESPOND: begin
               // Mismatch flag is only meaningful alongside a valid response.
               if (rsp_ready) begin
                  r_rsp_valid    <= 1'b0;
                  r_rsp_mismatch <= 1'b0;
                  r_state        <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign alu_operand1  = r_op1;
   assign alu_operand2  = r_op2;
   assign alu_operation = r_opc;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_result    = r_rsp_result;
   assign rsp_opcode    = r_rsp_opcode;
   assign rsp_mismatch  = r_rsp_mismatch;
   assign err_count     = r_err_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: behavioural ALU with fault injection plus a
// queue-based scoreboard of expected responses.
module tb_alu_cmd_sequencer;
   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int MOD   = 1 << (N + 1);

   logic         clk = 1'b0;
   logic         reset;
   logic         req_valid;
   logic         req_ready;
   logic [N-1:0] req_op1;
   logic [N-1:0] req_op2;
   logic [1:0]   req_opcode;
   logic [N-1:0] alu_operand1;
   logic [N-1:0] alu_operand2;
   logic [1:0]   alu_operation;
   logic [N:0]   alu_result;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [N:0]   rsp_result;
   logic [1:0]   rsp_opcode;
   logic         rsp_mismatch;
   logic [7:0]   err_count;

   logic         fault;

   alu_cmd_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op1       (req_op1),
      .req_op2       (req_op2),
      .req_opcode    (req_opcode),
      .alu_operand1  (alu_operand1),
      .alu_operand2  (alu_operand2),
      .alu_operation (alu_operation),
      .alu_result    (alu_result),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_result    (rsp_result),
      .rsp_opcode    (rsp_opcode),
      .rsp_mismatch  (rsp_mismatch),
      .err_count     (err_count)
   );

   always #5 clk = ~clk;

   // Reference arithmetic in plain integers, reduced modulo 2^(N+1).
   function automatic int ref_result(input int a, input int b, input int op);
      case (op)
         0:       return (a + b) % MOD;
         1:       return ((a - b) % MOD + MOD) % MOD;
         2:       return a & b;
         default: return a | b;
      endcase
   endfunction

   // The external combinational ALU, optionally off by one.
   assign alu_result = ref_result(int'(alu_operand1), int'(alu_operand2), int'(alu_operation))
                       + {{N{1'b0}}, fault};

   typedef struct {
      int res;
      int opc;
      bit mis;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   exp_err  = 0;
   int   last_lat = 0;
   bit   rsp_seen = 0;
   bit   pushed   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, evaluate handshakes, score any visible response.
   task automatic do_cycle(input bit v, input int a, input int b, input int opc, input bit rr);
      exp_t e;
      @(negedge clk);
      req_valid  = v;
      req_op1    = a[N-1:0];
      req_op2    = b[N-1:0];
      req_opcode = opc[1:0];
      rsp_ready  = rr;
      #1;
      pushed = 1'b0;
      if (v && req_ready) begin
         e.res = ref_result(a % (1 << N), b % (1 << N), opc % 4);
         e.mis = fault;
         if (fault) e.res = (e.res + 1) % MOD;
         e.opc = opc % 4;
         e.cyc = cyc;
         sb.push_back(e);
         pushed = 1'b1;
      end
      if (rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp_valid", 32'(rsp_valid), 0);
         end else begin
            if (!rsp_seen) begin
               rsp_seen = 1'b1;
               last_lat = cyc - sb[0].cyc;
               if (sb[0].mis) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
               $display("rsp: result=%0d opcode=%0d mismatch=%0d err_count=%0d latency=%0d",
                        rsp_result, rsp_opcode, rsp_mismatch, err_count, last_lat);
            end
            chk("rsp_result", 32'(rsp_result), sb[0].res);
            chk("rsp_opcode", 32'(rsp_opcode), sb[0].opc);
            chk("rsp_mismatch", 32'(rsp_mismatch), 32'(sb[0].mis));
            chk("err_count", 32'(err_count), exp_err);
            if (rr) begin
               void'(sb.pop_front());
               rsp_seen = 1'b0;
            end
         end
      end else begin
         chk("mismatch_while_idle", 32'(rsp_mismatch), 0);
      end
      cyc++;
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         if (sb.size() == 0 && rsp_valid === 1'b0) break;
         do_cycle(0, 0, 0, 0, 1);
      end
      chk("drain_outstanding", sb.size(), 0);
   endtask

   task automatic send_one(input int a, input int b, input int opc);
      bit done;
      done = 0;
      for (int i = 0; i < 50 && !done; i++) begin
         do_cycle(1, a, b, opc, 1);
         done = pushed;
      end
      if (!done) chk("push_timeout", 32'(req_ready), 1);
      drain();
   endtask

   initial begin
      int idx;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_op1    = '0;
      req_op2    = '0;
      req_opcode = '0;
      rsp_ready  = 1'b0;
      fault      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_req_ready", 32'(req_ready), 1);
      chk("reset_rsp_valid", 32'(rsp_valid), 0);
      chk("reset_rsp_result", 32'(rsp_result), 0);
      chk("reset_rsp_opcode", 32'(rsp_opcode), 0);
      chk("reset_rsp_mismatch", 32'(rsp_mismatch), 0);
      chk("reset_err_count", 32'(err_count), 0);
      chk("reset_alu_operand1", 32'(alu_operand1), 0);
      chk("reset_alu_operand2", 32'(alu_operand2), 0);
      chk("reset_alu_operation", 32'(alu_operation), 0);

      // Single add and its latency from push.
      send_one(7, 8, 0);
      chk("first_latency", last_lat, 4);

      // Directed arithmetic incl. subtract wrap and add carry.
      send_one(3, 5, 1);
      send_one(15, 15, 0);
      send_one(12, 10, 2);
      send_one(12, 3, 3);
      send_one(0, 1, 1);

      // Backpressure: 1 in flight + DEPTH buffered, 6th is held off.
      idx = 0;
      for (int i = 0; i < 10; i++) begin
         do_cycle(idx < 6, idx + 1, 2 * idx, idx % 4, 0);
         if (pushed) idx++;
      end
      chk("bp_pushed_count", idx, 5);
      chk("bp_req_ready_low", 32'(req_ready), 0);
      for (int i = 0; i < 40 && idx < 6; i++) begin
         do_cycle(1, idx + 1, 2 * idx, idx % 4, 1);
         if (pushed) idx++;
      end
      chk("bp_sixth_pushed", idx, 6);
      drain();

      // Fault on the middle of three requests.
      send_one(9, 4, 1);
      fault = 1'b1;
      send_one(6, 5, 0);
      fault = 1'b0;
      send_one(10, 6, 3);
      chk("err_after_fault", 32'(err_count), 1);

      // Reset while the first request is in CAPTURE with two more queued.
      for (int i = 0; i < 3; i++) do_cycle(1, i + 2, i + 1, i % 4, 0);
      @(negedge clk);
      reset     = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midreset_rsp_valid", 32'(rsp_valid), 0);
      chk("midreset_req_ready", 32'(req_ready), 1);
      chk("midreset_err_count", 32'(err_count), 0);
      sb.delete();
      exp_err  = 0;
      rsp_seen = 1'b0;
      for (int i = 0; i < 12; i++) do_cycle(0, 0, 0, 0, 1);
      chk("no_stale_rsp", 32'(rsp_valid), 0);
      send_one(5, 5, 0);

      // Random traffic with random backpressure.
      for (int i = 0; i < 400; i++)
         do_cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0);
      drain();

      // Saturation of the error counter.
      fault = 1'b1;
      for (int i = 0; i < 260; i++)
         send_one(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)));
      fault = 1'b0;
      chk("err_saturated", 32'(err_count), 255);
      send_one(1, 2, 0);
      chk("err_still_saturated", 32'(err_count), 255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
